bram_pixel_writer: RTL and testbench
====================================

Name: bram_pixel_writer

Overview:
- Packs an incoming raster pixel stream into 8-pixel chunks and writes each chunk into one of four BRAM banks, selected by row parity and chunk parity.
- This is the fill side of the undistort frame buffer. The banked layout lets the bilinear reader fetch the four neighbouring chunks (top-left, top-right, bottom-left, bottom-right) in one cycle.
- Upstream is the camera pixel source (valid/ready). Downstream is the same 4-bank BRAM the undistort reader reads.

Parameters:
- ADDR_WIDTH, 12, per-bank address width.
- DATA_WIDTH, 256, total BRAM data bus (4 banks x 64 bits).
- PIXEL_PER_ADDRESS, 8, pixels per chunk/bank word.
- BITS_PER_PIXEL, 8, pixel width.
- IMAGE_WIDTH, 256, pixels per row; must be a multiple of 2*PIXEL_PER_ADDRESS.
- IMAGE_HEIGHT, 256, rows per frame; must be even.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame.
- pixel_in  in  BITS_PER_PIXEL  raster-order pixel.
- pixel_valid  in  1  pixel_in valid.
- pixel_ready  out  1  writer accepts pixel_in this cycle.
- bram_addr  out  4*ADDR_WIDTH  {addr_oo, addr_oe, addr_eo, addr_ee}, same slice order as the reader.
- bram_din  out  DATA_WIDTH  {din_oo, din_oe, din_eo, din_ee}, 64 bits each.
- bram_we  out  4  per-bank write enable; bit3=oo, bit2=oe, bit1=eo, bit0=ee.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after the last write of a frame.

Behaviour:
Bank naming and addressing:
- Bank name = {row parity, chunk parity}: e=even, o=odd. Example: oe = odd row, even chunk.
- chunk = column / PIXEL_PER_ADDRESS.
- Bank address = (row>>1)*(IMAGE_WIDTH/(2*PIXEL_PER_ADDRESS)) + (chunk>>1), truncated to ADDR_WIDTH.
- Within a 64-bit bank word, the first pixel of the chunk goes in the MSB byte and the eighth pixel in the LSB byte.
- bram_addr and bram_din drive the same address and data on all four slices. Only the selected bank's bram_we bit is set. The eventual one-hot check relies on this.

Reset (rst low, any time, asynchronous):
- State returns to IDLE. All counters and the shift register clear.
- Outputs: pixel_ready=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, frame_done=0.
- A partial chunk is discarded. No write is issued after reset deasserts.

State machine:
- IDLE: pixel_ready=0, busy=0.
  - On start: clear row, chunk and byte counters, then go to FILL.
- FILL: pixel_ready=1, busy=1.
  - Each handshake (pixel_valid & pixel_ready) shifts pixel_in into the 64-bit shift register and increments the byte index (0..7).
  - On the 8th handshake, the full word, bank select and address are registered. bram_we asserts for exactly one cycle on the next cycle. Accepting pixels continues with no stall.
  - Counters: chunk increments and wraps at IMAGE_WIDTH/PIXEL_PER_ADDRESS; row increments on chunk wrap.
  - On the 8th handshake of the last chunk of the last row, go to DONE. pixel_ready drops the following cycle.
  - start while in FILL restarts the frame: counters and shift register clear, the partial chunk is discarded. A write already registered this cycle still completes.
- DONE: pixel_ready=0.
  - The last write issues in the first DONE cycle.
  - frame_done pulses for one cycle on the next cycle, concurrent with the return to IDLE and busy=0.

Timing and handshake:
- Latency: last pixel of a chunk accepted at cycle N -> bram_we high at cycle N+1 -> deasserted at N+2 unless another chunk completes.
- pixel_valid low simply stalls; no timeout.
- pixel_valid while pixel_ready is low is ignored.
- bram_we is never multi-hot.

Optional Feature:
BRAM_WRITER_PROTOCOL_CHECK_EN
- With the macro defined:
  - Adds output port err_protocol (1 bit, reset 0, sticky).
  - err_protocol sets on pixel_valid=1 while in IDLE or DONE.
  - It also sets on start received in FILL with byte index != 0.
  - It clears only on start received in IDLE.
- Without the macro:
  - The port and its logic are absent.
  - Behaviour is otherwise identical.

Test Plan:
1. Reset, start, pixels 0x00..0x07 with valid held high -> cycle after 8th accept: bram_we=4'b0001, addr_ee=0, din_ee=64'h0001020304050607.
2. Continue pixels 0x08..0x17 -> chunk1 gives bram_we=4'b0010, addr_eo=0. Chunk2 gives bram_we=4'b0001, addr_ee=1.
3. Row 1 chunk 0 -> bram_we=4'b0100, addr_oe=0. Row 2 chunk 0 -> bram_we=4'b0001, addr_ee=16.
4. Full 256x256 frame with random pixel_valid gaps -> exactly 8192 single-cycle writes. Last write: bram_we=4'b1000, addr_oo=2047. frame_done pulses once on the next cycle. busy and pixel_ready are then 0.
5. start after 5 pixels of chunk 0, then a fresh frame -> no write for the partial chunk. The first write contains the new pixels at addr_ee=0.
6. Assert rst mid-chunk (byte index 3), release, start -> all outputs 0 during reset, no stray bram_we, and the frame restarts cleanly at row 0 chunk 0. With BRAM_WRITER_PROTOCOL_CHECK_EN: pixel_valid in IDLE sets err_protocol=1, which clears on the next start in IDLE.

Source files
------------

// File: rtl/bram_pixel_writer.sv
// Packs a raster pixel stream into 8-pixel chunks and writes each chunk into one of four
// row/chunk-parity BRAM banks. Define BRAM_WRITER_PROTOCOL_CHECK_EN to add the sticky err_protocol output.
module bram_pixel_writer #(
    parameter int ADDR_WIDTH        = 12,
    parameter int DATA_WIDTH        = 256,
    parameter int PIXEL_PER_ADDRESS = 8,
    parameter int BITS_PER_PIXEL    = 8,
    parameter int IMAGE_WIDTH       = 256,
    parameter int IMAGE_HEIGHT      = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BITS_PER_PIXEL-1:0] pixel_in,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    output logic [4*ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]     bram_din,
    output logic [3:0]                bram_we,
    output logic                      busy,
    output logic                      frame_done
`ifdef BRAM_WRITER_PROTOCOL_CHECK_EN
    ,
    output logic                      err_protocol
`endif
);

    localparam int WORD_W             = DATA_WIDTH / 4;
    localparam int CHUNKS_PER_ROW     = IMAGE_WIDTH / PIXEL_PER_ADDRESS;
    localparam int WORDS_PER_ROW_PAIR = IMAGE_WIDTH / (2 * PIXEL_PER_ADDRESS);
    localparam int BYTE_W  = (PIXEL_PER_ADDRESS > 1) ? $clog2(PIXEL_PER_ADDRESS) : 1;
    localparam int CHUNK_W = (CHUNKS_PER_ROW > 1) ? $clog2(CHUNKS_PER_ROW) : 1;
    localparam int ROW_W   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [BYTE_W-1:0]  LAST_BYTE  = BYTE_W'(PIXEL_PER_ADDRESS - 1);
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS_PER_ROW - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [BYTE_W-1:0]     byte_q;
    logic [CHUNK_W-1:0]    chunk_q;
    logic [ROW_W-1:0]      row_q;
    logic [WORD_W-1:0]     shift_q;
    logic [WORD_W-1:0]     shift_next;
    logic [ADDR_WIDTH-1:0] addr_calc;
    logic                  accept;
    logic                  chunk_full;
    logic                  chunk_last;
    logic                  row_last;
    logic                  restart;

    // A start pulse wins over a pixel offered in the same cycle; that pixel is dropped with the partial chunk.
    assign accept     = (state == S_FILL) && pixel_valid && !start;
    assign chunk_full = accept && (byte_q == LAST_BYTE);
    assign chunk_last = (chunk_q == LAST_CHUNK);
    assign row_last   = (row_q == LAST_ROW);
    assign restart    = start && (state != S_DONE);

    // First pixel of a chunk ends up in the most significant byte.
    assign shift_next = {shift_q[WORD_W-BITS_PER_PIXEL-1:0], pixel_in};
    assign addr_calc  = ADDR_WIDTH'(32'(row_q >> 1) * 32'(WORDS_PER_ROW_PAIR) + 32'(chunk_q >> 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        pixel_ready = 1'b0;
        busy        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FILL;
                end
            end
            S_FILL: begin
                pixel_ready = 1'b1;
                busy        = 1'b1;
                if (chunk_full && chunk_last && row_last) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_q     <= '0;
            chunk_q    <= '0;
            row_q      <= '0;
            shift_q    <= '0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            frame_done <= 1'b0;
        end else begin
            bram_we    <= '0;
            frame_done <= (state == S_DONE);
            if (restart) begin
                byte_q  <= '0;
                chunk_q <= '0;
                row_q   <= '0;
                shift_q <= '0;
            end else if (accept) begin
                shift_q <= shift_next;
                if (byte_q == LAST_BYTE) begin
                    byte_q    <= '0;
                    bram_we   <= 4'b0001 << {row_q[0], chunk_q[0]};
                    bram_addr <= {4{addr_calc}};
                    bram_din  <= {4{shift_next}};
                    if (chunk_last) begin
                        chunk_q <= '0;
                        row_q   <= row_last ? '0 : row_q + ROW_W'(1);
                    end else begin
                        chunk_q <= chunk_q + CHUNK_W'(1);
                    end
                end else begin
                    byte_q <= byte_q + BYTE_W'(1);
                end
            end
        end
    end

`ifdef BRAM_WRITER_PROTOCOL_CHECK_EN
    // Sticky: a pixel offered outside FILL, or a restart that abandons a partial chunk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_protocol <= 1'b0;
        end else if ((state == S_IDLE || state == S_DONE) && pixel_valid) begin
            err_protocol <= 1'b1;
        end else if (start && state == S_FILL && byte_q != '0) begin
            err_protocol <= 1'b1;
        end else if (start && state == S_IDLE) begin
            err_protocol <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_bram_pixel_writer.sv
// Self-checking bench for bram_pixel_writer: a pixel-count based reference model checked every
// cycle, plus literal expectations for specific writes, restart, and reset behaviour.
module tb_bram_pixel_writer;

    localparam int W = 256;
    localparam int H = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   pixel_in = 8'h00;
    logic         pixel_valid = 1'b0;
    logic         pixel_ready;
    logic [47:0]  bram_addr;
    logic [255:0] bram_din;
    logic [3:0]   bram_we;
    logic         busy;
    logic         frame_done;
`ifdef BRAM_WRITER_PROTOCOL_CHECK_EN
    logic         err_protocol;
`endif

    bram_pixel_writer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pixel_in    (pixel_in),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_we     (bram_we),
        .busy        (busy),
        .frame_done  (frame_done)
`ifdef BRAM_WRITER_PROTOCOL_CHECK_EN
        ,
        .err_protocol(err_protocol)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks pixels accepted in the frame and derives bank/address from the pixel index.
    typedef enum {M_IDLE, M_FILL, M_DONE} mstate_t;
    mstate_t    ms = M_IDLE;
    int         k = 0;
    logic [7:0] cq[$];
    logic       e_ready = 1'b0;
    logic       e_busy = 1'b0;
    logic       e_fd = 1'b0;
    logic       e_err = 1'b0;
    logic [3:0] e_we = 4'b0;
    logic [11:0] e_addr = 12'h0;
    logic [63:0] e_din = 64'h0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms = M_IDLE;
            k = 0;
            cq.delete();
            e_ready = 0; e_busy = 0; e_fd = 0; e_err = 0;
            e_we = 0; e_addr = 0; e_din = 0;
        end else begin
            int p, row, chunk;
            e_we = 0;
            e_fd = 0;
            if ((ms == M_IDLE || ms == M_DONE) && pixel_valid) e_err = 1;
            else if (start && ms == M_FILL && cq.size() != 0) e_err = 1;
            else if (start && ms == M_IDLE) e_err = 0;
            case (ms)
                M_IDLE: if (start) begin
                    k = 0;
                    cq.delete();
                    ms = M_FILL;
                end
                M_FILL: if (start) begin
                    k = 0;
                    cq.delete();
                end else if (pixel_valid) begin
                    cq.push_back(pixel_in);
                    k++;
                    if (cq.size() == 8) begin
                        p = k - 1;
                        row = p / W;
                        chunk = (p % W) / 8;
                        e_addr = 12'((row / 2) * (W / 16) + chunk / 2);
                        e_we = 4'(1 << ((row % 2) * 2 + chunk % 2));
                        for (int i = 0; i < 8; i++) e_din[63-8*i -: 8] = cq[i];
                        cq.delete();
                        if (k == W * H) ms = M_DONE;
                    end
                end
                M_DONE: begin
                    e_fd = 1;
                    ms = M_IDLE;
                end
                default: ms = M_IDLE;
            endcase
            e_ready = (ms == M_FILL);
            e_busy = (ms != M_IDLE);
        end
    end

    int          writes_seen = 0;
    int          fd_seen = 0;
    logic [3:0]  wlog_we[$];
    logic [11:0] wlog_addr[$];
    logic [63:0] wlog_din[$];

    always @(negedge clk) begin
        check("pixel_ready", pixel_ready, e_ready);
        check("busy", busy, e_busy);
        check("frame_done", frame_done, e_fd);
        check("bram_we", bram_we, e_we);
        check("we_onehot0", $onehot0(bram_we), 1'b1);
        if (e_we != 0) begin
            check("bram_addr", bram_addr, {4{e_addr}});
            check("bram_din", bram_din, {4{e_din}});
        end
`ifdef BRAM_WRITER_PROTOCOL_CHECK_EN
        check("err_protocol", err_protocol, e_err);
`endif
        if (bram_we != 0) begin
            writes_seen++;
            wlog_we.push_back(bram_we);
            wlog_addr.push_back(bram_addr[11:0]);
            wlog_din.push_back(bram_din[63:0]);
        end
        if (frame_done) fd_seen++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    // Offers one pixel and returns just after the edge that accepted it; valid stays high.
    task automatic push(input logic [7:0] v, output bit ok);
        logic hs;
        ok = 0;
        pixel_in = v;
        pixel_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            hs = pixel_ready;
            @(posedge clk);
            #1;
            if (hs) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_handshake: pixel %0h not accepted within 100 cycles", v);
        end
    endtask

    task automatic push_run(input logic [7:0] base, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            push(base + 8'(i), ok);
            if (!ok) break;
        end
        pixel_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, pixel_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_we"}, bram_we, 4'b0);
        check({tag, "_addr"}, bram_addr, 48'h0);
        check({tag, "_din"}, bram_din, 256'h0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
`ifdef BRAM_WRITER_PROTOCOL_CHECK_EN
        check({tag, "_err"}, err_protocol, 1'b0);
`endif
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_w, b_fd;
        bit ok;

        // Reset state
        cycles(3);
        check_all_zero("reset");
        rst = 1'b1;
        cycles(2);

        // Full frame: first 520 pixels back to back, then random valid gaps
        b_w = writes_seen;
        b_fd = fd_seen;
        pulse_start();
        for (int i = 0; i < W * H; i++) begin
            push(8'(i), ok);
            if (!ok) break;
            if (i >= 520 && $urandom_range(0, 63) == 0) begin
                pixel_valid = 1'b0;
                cycles($urandom_range(1, 3));
            end
        end
        pixel_valid = 1'b0;
        cycles(4);

        check("t1_we", wlog_we[b_w+0], 4'b0001);
        check("t1_addr", wlog_addr[b_w+0], 12'd0);
        check("t1_din", wlog_din[b_w+0], 64'h0001020304050607);
        check("t2_c1_we", wlog_we[b_w+1], 4'b0010);
        check("t2_c1_addr", wlog_addr[b_w+1], 12'd0);
        check("t2_c1_din", wlog_din[b_w+1], 64'h08090a0b0c0d0e0f);
        check("t2_c2_we", wlog_we[b_w+2], 4'b0001);
        check("t2_c2_addr", wlog_addr[b_w+2], 12'd1);
        check("t3_r1_we", wlog_we[b_w+32], 4'b0100);
        check("t3_r1_addr", wlog_addr[b_w+32], 12'd0);
        check("t3_r2_we", wlog_we[b_w+64], 4'b0001);
        check("t3_r2_addr", wlog_addr[b_w+64], 12'd16);
        check("t4_write_count", 32'(writes_seen - b_w), 32'd8192);
        check("t4_last_we", wlog_we[b_w+8191], 4'b1000);
        check("t4_last_addr", wlog_addr[b_w+8191], 12'd2047);
        check("t4_last_din", wlog_din[b_w+8191], 64'hf8f9fafbfcfdfeff);
        check("t4_frame_done_count", 32'(fd_seen - b_fd), 32'd1);
        check("t4_ready_after", pixel_ready, 1'b0);
        check("t4_busy_after", busy, 1'b0);

        // Restart mid-chunk: the 5-pixel partial chunk must vanish
        pulse_start();
        push_run(8'hA0, 5);
        b_w = writes_seen;
        pulse_start();
        push_run(8'hB0, 8);
        cycles(2);
        check("t5_write_count", 32'(writes_seen - b_w), 32'd1);
        check("t5_we", wlog_we[b_w], 4'b0001);
        check("t5_addr", wlog_addr[b_w], 12'd0);
        check("t5_din", wlog_din[b_w], 64'hb0b1b2b3b4b5b6b7);

        // Reset at byte index 3, then a clean restart
        push_run(8'hC0, 3);
        b_w = writes_seen;
        rst = 1'b0;
        #2;
        check_all_zero("t6_in_reset");
        cycles(2);
        rst = 1'b1;
        cycles(3);
        check("t6_no_stray_write", 32'(writes_seen - b_w), 32'd0);
        check("t6_idle_ready", pixel_ready, 1'b0);
        pixel_valid = 1'b1;
        pixel_in = 8'hEE;
        cycles(1);
        pixel_valid = 1'b0;
        @(negedge clk);
`ifdef BRAM_WRITER_PROTOCOL_CHECK_EN
        check("t6_err_set", err_protocol, 1'b1);
`endif
        check("t6_idle_valid_ignored", pixel_ready, 1'b0);
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
`ifdef BRAM_WRITER_PROTOCOL_CHECK_EN
        check("t6_err_cleared", err_protocol, 1'b0);
`endif
        @(posedge clk);
        #1;
        b_w = writes_seen;
        push_run(8'hD0, 8);
        cycles(2);
        check("t6_write_count", 32'(writes_seen - b_w), 32'd1);
        check("t6_we", wlog_we[b_w], 4'b0001);
        check("t6_addr", wlog_addr[b_w], 12'd0);
        check("t6_din", wlog_din[b_w], 64'hd0d1d2d3d4d5d6d7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
